hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Pipeline control block that drives the stall/bubble input of the decode-to-execute register and the hold/flush controls of the PC and fetch/decode register. Three conditions are resolved: load-use hazards, taken-branch/jump flushes, and multi-cycle floating-point structural stalls, timed by an internal latency counter. It also keeps a saturating count of stall cycles. It sits beside the decode stage, taking register fields from decode and control bits from the decode/execute register outputs.

## Interface

**Parameters**
- FP_ADD_LAT, 3, execute-stage cycles for FP add/sub (FP_ALUop 0–3); legal range 1–31.
- FP_MUL_LAT, 5, cycles for FP multiply (FP_ALUop 4); legal range 1–31.
- FP_DIV_LAT, 12, cycles for FP divide (FP_ALUop 5); legal range 1–31.

**Ports**
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs1  in  5  rs1 field of the instruction in decode.
- id_rs2  in  5  rs2 field of the instruction in decode.
- id_uses_rs2  in  1  decode instruction reads rs2.
- id_fp_instruction  in  1  decode instruction is an FP op.
- id_fp_aluop  in  4  FP ALU op of the decode instruction.
- de_memread  in  1  Memread out of the decode/execute register (load in EX).
- de_rd  in  5  destination register of the instruction in EX.
- ex_branch_taken  in  1  branch resolved taken in EX.
- ex_jump  in  1  jump in EX.
- pc_write  out  1  1 = PC updates.
- fd_write  out  1  1 = fetch/decode register loads.
- fd_flush  out  1  1 = fetch/decode register loads a NOP.
- de_bubble  out  1  drives the decode register's register_write; 1 = bubble inserted.
- fp_busy  out  1  1 while in FP_WAIT.
- stall_cycles  out  16  saturating count of cycles with pc_write = 0.

## Operation

- State: FSM {RUN, FP_WAIT}; 5-bit fp_cnt; 16-bit stall_cycles.
- pc_write, fd_write, fd_flush and de_bubble are combinational from state and inputs. fp_busy and stall_cycles are registered.

**Hazard conditions**
- flush = ex_branch_taken | ex_jump.
- load_use = de_memread & (de_rd != 0) & ((de_rd == id_rs1) | (id_uses_rs2 & (de_rd == id_rs2))).

**Latency select**
- id_fp_aluop 0–3 gives FP_ADD_LAT.
- id_fp_aluop 4 gives FP_MUL_LAT.
- id_fp_aluop 5 gives FP_DIV_LAT.
- Any other value gives 1.

**Output priority**, highest first:
1. rst_n low: pc_write = 0, fd_write = 0, fd_flush = 1, de_bubble = 1.
2. flush: pc_write = 1, fd_write = 1, fd_flush = 1, de_bubble = 1. The next state is RUN and fp_cnt is cleared, including from FP_WAIT (abort).
3. FP_WAIT: pc_write = 0, fd_write = 0, fd_flush = 0, de_bubble = 1. fp_cnt decrements; when fp_cnt == 1, the next state is RUN.
4. load_use (RUN only): pc_write = 0, fd_write = 0, fd_flush = 0, de_bubble = 1. The state stays RUN.
5. Otherwise: pc_write = 1, fd_write = 1, fd_flush = 0, de_bubble = 0.

**FP issue**
- Issue occurs in RUN when id_fp_instruction is 1, there is no flush and there is no load_use; the FP op advances into the decode/execute register that cycle.
- If its latency L > 1: next state FP_WAIT, fp_cnt loaded with L-1.
- If L = 1: stay RUN.

**Stall counter**
- stall_cycles increments on every cycle with rst_n high and pc_write = 0.
- It holds at 16'hFFFF.

## Timing

- Reset values: FSM = RUN, fp_cnt = 0, fp_busy = 0, stall_cycles = 0. Combinational outputs are forced as in priority 1 while rst_n is low. Reset assertion takes effect immediately, regardless of clk.
- Load-use stall lasts exactly 1 cycle. The bubble then occupies EX, so load_use deasserts on the next cycle unless a new matching load is present.
- After an FP op of latency L issues at edge N, the stall cycles are N+1 … N+L-1 (L-1 cycles) and fp_busy is 1 during them. Decode resumes at N+L.
- A flush coincident with FP issue: the flush wins, fp_cnt is not loaded and the FP op is squashed.
- Load_use together with id_fp_instruction: the stall wins and the FP op is issued on the following cycle.
- Flush combined with load_use: the flush wins and there is no stall.
- Register 0 never causes a load-use stall.

## Test plan

- Reset: hold rst_n = 0 for 3 cycles → pc_write = 0, fd_flush = 1, de_bubble = 1, stall_cycles = 0, fp_busy = 0. Release → RUN with all pass-through outputs.
- Load-use: de_memread = 1, de_rd = 7, id_rs2 = 7, id_uses_rs2 = 1 for one cycle → exactly 1 cycle of pc_write = 0, de_bubble = 1, and stall_cycles = 1. Repeat with de_rd = 0 → no stall.
- FP multiply: issue id_fp_aluop = 4 (L = 5) → fp_busy = 1 and de_bubble = 1 for 4 cycles, pc_write returns to 1 on the 5th cycle, stall_cycles = 4. FP_ALUop 9 → no stall.
- Flush priority: ex_branch_taken = 1 in the same cycle as an FP divide issue and a load_use → fd_flush = 1, de_bubble = 1, pc_write = 1, fp_busy stays 0.
- Abort: ex_jump = 1 on the 2nd cycle of an FP_DIV_LAT = 12 wait → FSM returns to RUN and fp_busy = 0 on the next cycle.
- Saturation: hold a continuous FP stall (or force the counter) past 65535 stalled cycles → stall_cycles stays at 16'hFFFF.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - pipeline hazard and stall control for PC, fetch/decode and decode/execute registers
//
// Resolves load-use hazards, taken-branch/jump flushes and multi-cycle FP
// structural stalls (timed by an internal latency counter). Also keeps a
// saturating count of cycles in which the PC is held.
//
// Ports:
//   clk, rst_n          pipeline clock, asynchronous active-low reset
//   id_rs1, id_rs2      source register fields of the instruction in decode
//   id_uses_rs2         decode instruction reads rs2
//   id_fp_instruction   decode instruction is an FP op
//   id_fp_aluop         FP ALU op of the decode instruction (selects latency)
//   de_memread, de_rd   load-in-EX flag and its destination register
//   ex_branch_taken     branch resolved taken in EX
//   ex_jump             jump in EX
//   pc_write            1 = PC updates
//   fd_write            1 = fetch/decode register loads
//   fd_flush            1 = fetch/decode register loads a NOP
//   de_bubble           1 = bubble inserted into decode/execute register
//   fp_busy             1 while waiting on a multi-cycle FP op (registered)
//   stall_cycles        saturating count of cycles with pc_write = 0

module hazard_stall_unit #(
  parameter int unsigned FP_ADD_LAT = 3,
  parameter int unsigned FP_MUL_LAT = 5,
  parameter int unsigned FP_DIV_LAT = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs2,
  input  logic        id_fp_instruction,
  input  logic [3:0]  id_fp_aluop,
  input  logic        de_memread,
  input  logic [4:0]  de_rd,
  input  logic        ex_branch_taken,
  input  logic        ex_jump,
  output logic        pc_write,
  output logic        fd_write,
  output logic        fd_flush,
  output logic        de_bubble,
  output logic        fp_busy,
  output logic [15:0] stall_cycles
);

  localparam logic [4:0] ADD_L = 5'(FP_ADD_LAT);
  localparam logic [4:0] MUL_L = 5'(FP_MUL_LAT);
  localparam logic [4:0] DIV_L = 5'(FP_DIV_LAT);

  typedef enum logic {RUN, FP_WAIT} state_t;

  state_t     state, state_n;
  logic [4:0] fp_cnt, fp_cnt_n;
  logic [4:0] lat;
  logic       flush;
  logic       load_use;

  assign flush = ex_branch_taken | ex_jump;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = de_memread && (de_rd != 5'd0) &&
                    ((de_rd == id_rs1) || (id_uses_rs2 && (de_rd == id_rs2)));

  always_comb begin
    lat = 5'd1;
    case (id_fp_aluop)
      4'd0, 4'd1, 4'd2, 4'd3: lat = ADD_L;
      4'd4:                   lat = MUL_L;
      4'd5:                   lat = DIV_L;
      default:                lat = 5'd1;
    endcase
  end

  always_comb begin
    state_n   = state;
    fp_cnt_n  = fp_cnt;
    pc_write  = 1'b1;
    fd_write  = 1'b1;
    fd_flush  = 1'b0;
    de_bubble = 1'b0;

    if (!rst_n) begin
      pc_write  = 1'b0;
      fd_write  = 1'b0;
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
    end else if (flush) begin
      // Redirect wins over everything, including an in-flight FP wait.
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
      state_n   = RUN;
      fp_cnt_n  = 5'd0;
    end else if (state == FP_WAIT) begin
      pc_write  = 1'b0;
      fd_write  = 1'b0;
      de_bubble = 1'b1;
      if (fp_cnt <= 5'd1) begin
        state_n  = RUN;
        fp_cnt_n = 5'd0;
      end else begin
        fp_cnt_n = fp_cnt - 5'd1;
      end
    end else if (load_use) begin
      pc_write  = 1'b0;
      fd_write  = 1'b0;
      de_bubble = 1'b1;
    end else if (id_fp_instruction && (lat > 5'd1)) begin
      // The FP op advances into EX this cycle; hold decode for the rest of its latency.
      state_n  = FP_WAIT;
      fp_cnt_n = lat - 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      fp_cnt       <= 5'd0;
      fp_busy      <= 1'b0;
      stall_cycles <= 16'd0;
    end else begin
      state   <= state_n;
      fp_cnt  <= fp_cnt_n;
      fp_busy <= (state_n == FP_WAIT);
      if (!pc_write && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard testbench for hazard_stall_unit

module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic        id_uses_rs2 = 1'b0;
  logic        id_fp_instruction = 1'b0;
  logic [3:0]  id_fp_aluop = '0;
  logic        de_memread = 1'b0;
  logic [4:0]  de_rd = '0;
  logic        ex_branch_taken = 1'b0;
  logic        ex_jump = 1'b0;
  logic        pc_write, fd_write, fd_flush, de_bubble, fp_busy;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_stall_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .id_uses_rs2       (id_uses_rs2),
    .id_fp_instruction (id_fp_instruction),
    .id_fp_aluop       (id_fp_aluop),
    .de_memread        (de_memread),
    .de_rd             (de_rd),
    .ex_branch_taken   (ex_branch_taken),
    .ex_jump           (ex_jump),
    .pc_write          (pc_write),
    .fd_write          (fd_write),
    .fd_flush          (fd_flush),
    .de_bubble         (de_bubble),
    .fp_busy           (fp_busy),
    .stall_cycles      (stall_cycles)
  );

  // {pc_write, fd_write, fd_flush, de_bubble}
  localparam logic [3:0] C_PASS  = 4'b1100;
  localparam logic [3:0] C_STALL = 4'b0001;
  localparam logic [3:0] C_FLUSH = 4'b1111;
  localparam logic [3:0] C_RST   = 4'b0011;

  typedef struct {
    string       name;
    logic [3:0]  ctl;
    logic        busy;
    logic [15:0] st;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                       input logic fpi, input logic [3:0] op, input logic mr,
                       input logic [4:0] rd, input logic br, input logic jp);
    id_rs1            = rs1;
    id_rs2            = rs2;
    id_uses_rs2       = u2;
    id_fp_instruction = fpi;
    id_fp_aluop       = op;
    de_memread        = mr;
    de_rd             = rd;
    ex_branch_taken   = br;
    ex_jump           = jp;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic exp_push(input string nm, input logic [3:0] ctl, input logic busy,
                          input logic [15:0] st);
    exp_t e;
    e.name = nm;
    e.ctl  = ctl;
    e.busy = busy;
    e.st   = st;
    q.push_back(e);
  endtask

  // Monitor: every cycle is an output sample; compare whenever an expectation is queued.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      n_total++;
      if ({pc_write, fd_write, fd_flush, de_bubble} === e.ctl &&
          fp_busy === e.busy && stall_cycles === e.st)
        n_pass++;
      else
        $display("FAIL %s: got ctl=%b busy=%b stall=%0d, expected ctl=%b busy=%b stall=%0d",
                 e.name, {pc_write, fd_write, fd_flush, de_bubble}, fp_busy, stall_cycles,
                 e.ctl, e.busy, e.st);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin : stim
    idle();
    for (int i = 0; i < 3; i++) begin
      cyc();
      exp_push("reset", C_RST, 1'b0, 16'd0);
    end
    cyc(); rst_n = 1'b1; exp_push("release", C_PASS, 1'b0, 16'd0);
    cyc(); idle(); exp_push("idle0", C_PASS, 1'b0, 16'd0);

    // Load-use through rs2
    cyc(); drive(5'd3, 5'd7, 1'b1, 1'b0, 4'd0, 1'b1, 5'd7, 1'b0, 1'b0);
    exp_push("lu_rs2", C_STALL, 1'b0, 16'd0);
    cyc(); idle(); exp_push("lu_after", C_PASS, 1'b0, 16'd1);
    // x0 destination never stalls
    cyc(); drive(5'd0, 5'd0, 1'b1, 1'b0, 4'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    exp_push("lu_x0", C_PASS, 1'b0, 16'd1);
    // rs2 match but rs2 not read
    cyc(); drive(5'd3, 5'd7, 1'b0, 1'b0, 4'd0, 1'b1, 5'd7, 1'b0, 1'b0);
    exp_push("lu_no_rs2", C_PASS, 1'b0, 16'd1);
    // Load-use through rs1
    cyc(); drive(5'd5, 5'd0, 1'b0, 1'b0, 4'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    exp_push("lu_rs1", C_STALL, 1'b0, 16'd1);
    cyc(); idle(); exp_push("lu_rs1_after", C_PASS, 1'b0, 16'd2);

    // FP multiply, L = 5: 4 stall cycles
    cyc(); drive(5'd1, 5'd2, 1'b1, 1'b1, 4'd4, 1'b0, 5'd0, 1'b0, 1'b0);
    exp_push("mul_issue", C_PASS, 1'b0, 16'd2);
    cyc(); idle(); exp_push("mul_w1", C_STALL, 1'b1, 16'd2);
    cyc(); exp_push("mul_w2", C_STALL, 1'b1, 16'd3);
    cyc(); exp_push("mul_w3", C_STALL, 1'b1, 16'd4);
    cyc(); exp_push("mul_w4", C_STALL, 1'b1, 16'd5);
    cyc(); exp_push("mul_done", C_PASS, 1'b0, 16'd6);

    // Undefined FP op: latency 1, no stall
    cyc(); drive(5'd1, 5'd2, 1'b1, 1'b1, 4'd9, 1'b0, 5'd0, 1'b0, 1'b0);
    exp_push("fp9_issue", C_PASS, 1'b0, 16'd6);
    cyc(); idle(); exp_push("fp9_after", C_PASS, 1'b0, 16'd6);

    // FP add (op 3), L = 3: 2 stall cycles
    cyc(); drive(5'd1, 5'd2, 1'b1, 1'b1, 4'd3, 1'b0, 5'd0, 1'b0, 1'b0);
    exp_push("add_issue", C_PASS, 1'b0, 16'd6);
    cyc(); idle(); exp_push("add_w1", C_STALL, 1'b1, 16'd6);
    cyc(); exp_push("add_w2", C_STALL, 1'b1, 16'd7);
    cyc(); exp_push("add_done", C_PASS, 1'b0, 16'd8);

    // Flush beats FP divide issue and load-use
    cyc(); drive(5'd7, 5'd0, 1'b0, 1'b1, 4'd5, 1'b1, 5'd7, 1'b1, 1'b0);
    exp_push("flush_prio", C_FLUSH, 1'b0, 16'd8);
    cyc(); idle(); exp_push("flush_after", C_PASS, 1'b0, 16'd8);

    // Divide (L = 12) aborted by a jump on its 2nd wait cycle
    cyc(); drive(5'd1, 5'd2, 1'b1, 1'b1, 4'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    exp_push("div_issue", C_PASS, 1'b0, 16'd8);
    cyc(); idle(); exp_push("div_w1", C_STALL, 1'b1, 16'd8);
    cyc(); drive(5'd0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    exp_push("div_abort", C_FLUSH, 1'b1, 16'd9);
    cyc(); idle(); exp_push("div_aborted", C_PASS, 1'b0, 16'd9);

    // Load-use with FP in decode: stall first, issue next cycle
    cyc(); drive(5'd4, 5'd0, 1'b0, 1'b1, 4'd4, 1'b1, 5'd4, 1'b0, 1'b0);
    exp_push("lu_fp", C_STALL, 1'b0, 16'd9);
    cyc(); drive(5'd4, 5'd0, 1'b0, 1'b1, 4'd4, 1'b0, 5'd0, 1'b0, 1'b0);
    exp_push("lu_fp_issue", C_PASS, 1'b0, 16'd10);
    cyc(); idle(); exp_push("lu_fp_w1", C_STALL, 1'b1, 16'd10);
    cyc(); exp_push("lu_fp_w2", C_STALL, 1'b1, 16'd11);
    cyc(); exp_push("lu_fp_w3", C_STALL, 1'b1, 16'd12);
    cyc(); exp_push("lu_fp_w4", C_STALL, 1'b1, 16'd13);
    cyc(); exp_push("lu_fp_done", C_PASS, 1'b0, 16'd14);

    // Held load-use stalls every cycle; counter saturates at 16'hFFFF
    for (int i = 0; i < 65530; i++) begin
      cyc();
      drive(5'd7, 5'd0, 1'b0, 1'b0, 4'd0, 1'b1, 5'd7, 1'b0, 1'b0);
      exp_push("saturate", C_STALL, 1'b0, (i + 14 > 65535) ? 16'hFFFF : 16'(i + 14));
    end

    // Asynchronous reset between clock edges
    cyc(); rst_n = 1'b0; exp_push("async_rst", C_RST, 1'b0, 16'd0);
    cyc(); rst_n = 1'b1; idle(); exp_push("post_rst", C_PASS, 1'b0, 16'd0);

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
